// File: rtl/snax_tcdm_credit_buffer.sv
// -----------------------------------------------------------------------------
// snax_tcdm_credit_buffer
//
// Purpose:
//   Elastic stage between the SNAX HWPE-to-reqrsp translator and one TCDM
//   interconnect port. Requests pass through a registered FIFO so accelerator
//   issue is decoupled from interconnect grant. Reads are bounded by a credit
//   counter so every TCDM read response has a guaranteed slot in the local
//   response FIFO (TCDM responses carry no ready).
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   in_q_*                     upstream request channel (valid/ready + payload)
//   in_p_*                     upstream read response channel (valid/ready + data)
//   out_q_*                    TCDM request channel (valid/ready + payload)
//   out_p_*                    TCDM read response (valid + data, no ready)
//   credit_o                   reads issued but not yet popped upstream
//   err_o                      sticky error: stray or overflowing response
//
// Optional build macro:
//   SNAX_TCDM_BUF_PERF_EN      adds perf_clr_i, perf_stall_credit_o and
//                              perf_stall_gnt_o (32-bit saturating counters).
// -----------------------------------------------------------------------------
module snax_tcdm_credit_buffer #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned CreditWidth   = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_q_valid_i,
  output logic                   in_q_ready_o,
  input  logic [AddrWidth-1:0]   in_q_addr_i,
  input  logic                   in_q_write_i,
  input  logic [DataWidth-1:0]   in_q_data_i,
  input  logic [StrbWidth-1:0]   in_q_strb_i,
  output logic                   in_p_valid_o,
  input  logic                   in_p_ready_i,
  output logic [DataWidth-1:0]   in_p_data_o,
  output logic                   out_q_valid_o,
  input  logic                   out_q_ready_i,
  output logic [AddrWidth-1:0]   out_q_addr_o,
  output logic                   out_q_write_o,
  output logic [DataWidth-1:0]   out_q_data_o,
  output logic [StrbWidth-1:0]   out_q_strb_o,
  input  logic                   out_p_valid_i,
  input  logic [DataWidth-1:0]   out_p_data_i,
  output logic [CreditWidth-1:0] credit_o,
`ifdef SNAX_TCDM_BUF_PERF_EN
  input  logic                   perf_clr_i,
  output logic [31:0]            perf_stall_credit_o,
  output logic [31:0]            perf_stall_gnt_o,
`endif
  output logic                   err_o
);

  // Pointers keep at least one bit so single-entry FIFOs still elaborate.
  localparam int unsigned ReqPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
  localparam int unsigned RspPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } req_t;

  function automatic logic [ReqPtrW-1:0] req_ptr_inc(input logic [ReqPtrW-1:0] p);
    if (p == ReqPtrW'(ReqDepth - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [RspPtrW-1:0] rsp_ptr_inc(input logic [RspPtrW-1:0] p);
    if (p == RspPtrW'(MaxOutstanding - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Request FIFO state
  req_t [ReqDepth-1:0]          req_mem_q, req_mem_d;
  logic [ReqPtrW-1:0]           req_wr_ptr_q, req_wr_ptr_d;
  logic [ReqPtrW-1:0]           req_rd_ptr_q, req_rd_ptr_d;
  logic [ReqCntW-1:0]           req_cnt_q, req_cnt_d;

  // Response FIFO state
  logic [MaxOutstanding-1:0][DataWidth-1:0] rsp_mem_q, rsp_mem_d;
  logic [RspPtrW-1:0]           rsp_wr_ptr_q, rsp_wr_ptr_d;
  logic [RspPtrW-1:0]           rsp_rd_ptr_q, rsp_rd_ptr_d;
  logic [CreditWidth-1:0]       rsp_cnt_q, rsp_cnt_d;

  logic [CreditWidth-1:0]       credit_q, credit_d;
  logic                         err_q, err_d;

  req_t                         req_head;
  logic                         req_full, req_empty, issue_ok;
  logic                         req_push, req_pop, read_issue;
  logic                         rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [CreditWidth-1:0]       in_flight;
  logic                         stray, overflow;

  // ---------------------------------------------------------------------------
  // Request side: head of the FIFO drives the TCDM request directly.
  // ---------------------------------------------------------------------------
  assign req_head  = req_mem_q[req_rd_ptr_q];
  assign req_full  = (req_cnt_q == ReqCntW'(ReqDepth));
  assign req_empty = (req_cnt_q == '0);
  // Credit only rises on a read issue, so a waiting head never loses issue_ok.
  assign issue_ok  = req_head.write | (credit_q < CreditWidth'(MaxOutstanding));

  assign in_q_ready_o  = ~req_full;
  assign out_q_valid_o = ~req_empty & issue_ok;
  assign out_q_addr_o  = req_head.addr;
  assign out_q_write_o = req_head.write;
  assign out_q_data_o  = req_head.data;
  assign out_q_strb_o  = req_head.strb;

  assign req_push   = in_q_valid_i & ~req_full;
  assign req_pop    = out_q_valid_o & out_q_ready_i;
  assign read_issue = req_pop & ~req_head.write;

  always_comb begin
    req_mem_d    = req_mem_q;
    req_wr_ptr_d = req_wr_ptr_q;
    req_rd_ptr_d = req_rd_ptr_q;
    req_cnt_d    = req_cnt_q;
    if (req_push) begin
      req_mem_d[req_wr_ptr_q] = '{addr:  in_q_addr_i,
                                  write: in_q_write_i,
                                  data:  in_q_data_i,
                                  strb:  in_q_strb_i};
      req_wr_ptr_d = req_ptr_inc(req_wr_ptr_q);
    end
    if (req_pop) req_rd_ptr_d = req_ptr_inc(req_rd_ptr_q);
    case ({req_push, req_pop})
      2'b10:   req_cnt_d = req_cnt_q + 1'b1;
      2'b01:   req_cnt_d = req_cnt_q - 1'b1;
      default: req_cnt_d = req_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response side: credit minus occupancy is the number of reads still in the
  // interconnect; a response arriving when that is zero has no owner.
  // ---------------------------------------------------------------------------
  assign rsp_full  = (rsp_cnt_q == CreditWidth'(MaxOutstanding));
  assign rsp_empty = (rsp_cnt_q == '0);
  assign in_flight = credit_q - rsp_cnt_q;

  assign in_p_valid_o = ~rsp_empty;
  assign in_p_data_o  = rsp_mem_q[rsp_rd_ptr_q];

  assign rsp_pop  = in_p_valid_o & in_p_ready_i;
  assign stray    = out_p_valid_i & (in_flight == '0);
  // A pop in the same cycle frees the slot, so only a full FIFO without pop overflows.
  assign overflow = out_p_valid_i & ~stray & rsp_full & ~rsp_pop;
  assign rsp_push = out_p_valid_i & ~stray & ~overflow;

  always_comb begin
    rsp_mem_d    = rsp_mem_q;
    rsp_wr_ptr_d = rsp_wr_ptr_q;
    rsp_rd_ptr_d = rsp_rd_ptr_q;
    rsp_cnt_d    = rsp_cnt_q;
    if (rsp_push) begin
      rsp_mem_d[rsp_wr_ptr_q] = out_p_data_i;
      rsp_wr_ptr_d = rsp_ptr_inc(rsp_wr_ptr_q);
    end
    if (rsp_pop) rsp_rd_ptr_d = rsp_ptr_inc(rsp_rd_ptr_q);
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
      2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_comb begin
    case ({read_issue, rsp_pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
    err_d = err_q | stray | overflow;
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_mem_q    <= '0;
      req_wr_ptr_q <= '0;
      req_rd_ptr_q <= '0;
      req_cnt_q    <= '0;
      rsp_mem_q    <= '0;
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
      rsp_cnt_q    <= '0;
      credit_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      req_mem_q    <= req_mem_d;
      req_wr_ptr_q <= req_wr_ptr_d;
      req_rd_ptr_q <= req_rd_ptr_d;
      req_cnt_q    <= req_cnt_d;
      rsp_mem_q    <= rsp_mem_d;
      rsp_wr_ptr_q <= rsp_wr_ptr_d;
      rsp_rd_ptr_q <= rsp_rd_ptr_d;
      rsp_cnt_q    <= rsp_cnt_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
    end
  end

`ifdef SNAX_TCDM_BUF_PERF_EN
  // ---------------------------------------------------------------------------
  // Stall counters: hold at all-ones instead of wrapping.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  logic [31:0] perf_stall_credit_q, perf_stall_credit_d;
  logic [31:0] perf_stall_gnt_q, perf_stall_gnt_d;

  always_comb begin
    perf_stall_credit_d = perf_stall_credit_q;
    perf_stall_gnt_d    = perf_stall_gnt_q;
    if (perf_clr_i) begin
      perf_stall_credit_d = '0;
      perf_stall_gnt_d    = '0;
    end else begin
      if (~req_empty & ~issue_ok) perf_stall_credit_d = sat_inc(perf_stall_credit_q);
      if (out_q_valid_o & ~out_q_ready_i) perf_stall_gnt_d = sat_inc(perf_stall_gnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_credit_q <= '0;
      perf_stall_gnt_q    <= '0;
    end else begin
      perf_stall_credit_q <= perf_stall_credit_d;
      perf_stall_gnt_q    <= perf_stall_gnt_d;
    end
  end

  assign perf_stall_credit_o = perf_stall_credit_q;
  assign perf_stall_gnt_o    = perf_stall_gnt_q;
`endif

endmodule

// File: tb/tb_snax_tcdm_credit_buffer.sv
// -----------------------------------------------------------------------------
// Bench for snax_tcdm_credit_buffer (default parameters, default build).
// A transaction-level model (request queue, response queue, credit integer,
// error bit) predicts every output each cycle; directed scenarios add literal
// expectations, followed by a randomized run with an in-order TCDM responder.
// -----------------------------------------------------------------------------
module tb_snax_tcdm_credit_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RD = 2;
  localparam int MO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_q_valid_i = 1'b0;
  logic          in_q_ready_o;
  logic [AW-1:0] in_q_addr_i = '0;
  logic          in_q_write_i = 1'b0;
  logic [DW-1:0] in_q_data_i = '0;
  logic [3:0]    in_q_strb_i = '0;
  logic          in_p_valid_o;
  logic          in_p_ready_i = 1'b0;
  logic [DW-1:0] in_p_data_o;
  logic          out_q_valid_o;
  logic          out_q_ready_i = 1'b0;
  logic [AW-1:0] out_q_addr_o;
  logic          out_q_write_o;
  logic [DW-1:0] out_q_data_o;
  logic [3:0]    out_q_strb_o;
  logic          out_p_valid_i = 1'b0;
  logic [DW-1:0] out_p_data_i = '0;
  logic [2:0]    credit_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  snax_tcdm_credit_buffer #(
    .DataWidth(DW), .AddrWidth(AW), .ReqDepth(RD), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_q_valid_i(in_q_valid_i), .in_q_ready_o(in_q_ready_o),
    .in_q_addr_i(in_q_addr_i), .in_q_write_i(in_q_write_i),
    .in_q_data_i(in_q_data_i), .in_q_strb_i(in_q_strb_i),
    .in_p_valid_o(in_p_valid_o), .in_p_ready_i(in_p_ready_i),
    .in_p_data_o(in_p_data_o),
    .out_q_valid_o(out_q_valid_o), .out_q_ready_i(out_q_ready_i),
    .out_q_addr_o(out_q_addr_o), .out_q_write_o(out_q_write_o),
    .out_q_data_o(out_q_data_o), .out_q_strb_o(out_q_strb_o),
    .out_p_valid_i(out_p_valid_i), .out_p_data_i(out_p_data_i),
    .credit_o(credit_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model
  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
    logic [3:0]  strb;
  } m_req_t;

  m_req_t      mq[$];
  logic [31:0] mr[$];
  int          mcred = 0;
  bit          merr  = 1'b0;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One cycle: drive inputs after the falling edge, compare every output to
  // the model, then advance the model by what the coming rising edge does.
  task automatic step(input bit qv, input logic [31:0] a, input bit wr,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit gnt, input bit pr, input bit rv, input logic [31:0] rd,
                      output bit pushed, output bit issued, output bit popped,
                      output logic [31:0] paddr);
    bit e_rdy, e_qv, e_pv, pop_rsp, stray, ovf;
    m_req_t h;
    @(negedge clk_i);
    in_q_valid_i  = qv;
    in_q_addr_i   = a;
    in_q_write_i  = wr;
    in_q_data_i   = d;
    in_q_strb_i   = s;
    out_q_ready_i = gnt;
    in_p_ready_i  = pr;
    out_p_valid_i = rv;
    out_p_data_i  = rd;
    #1;
    e_rdy = (mq.size() < RD);
    e_qv  = 1'b0;
    h     = '{addr: 32'h0, wr: 1'b0, data: 32'h0, strb: 4'h0};
    if (mq.size() > 0) begin
      h    = mq[0];
      e_qv = h.wr || (mcred < MO);
    end
    e_pv = (mr.size() > 0);
    chk("in_q_ready", in_q_ready_o, e_rdy);
    chk("out_q_valid", out_q_valid_o, e_qv);
    chk("in_p_valid", in_p_valid_o, e_pv);
    chk("credit", credit_o, mcred);
    chk("err", err_o, merr);
    if (e_qv) begin
      chk("out_q_addr", out_q_addr_o, h.addr);
      chk("out_q_write", out_q_write_o, h.wr);
      chk("out_q_data", out_q_data_o, h.data);
      chk("out_q_strb", out_q_strb_o, h.strb);
    end
    if (e_pv) chk("in_p_data", in_p_data_o, mr[0]);

    pushed  = qv && e_rdy;
    popped  = e_qv && gnt;
    issued  = popped && !h.wr;
    paddr   = popped ? h.addr : 32'h0;
    pop_rsp = e_pv && pr;
    stray   = rv && ((mcred - mr.size()) == 0);
    ovf     = rv && !stray && (mr.size() == MO) && !pop_rsp;
    if (popped) void'(mq.pop_front());
    if (pushed) mq.push_back(m_req_t'{addr: a, wr: wr, data: d, strb: s});
    if (pop_rsp) void'(mr.pop_front());
    if (rv) begin
      if (stray || ovf) merr = 1'b1;
      else mr.push_back(rd);
    end
    mcred = mcred + int'(issued) - int'(pop_rsp);
  endtask

  task automatic idle(input bit gnt, input bit pr, input bit rv, input logic [31:0] rd);
    bit pu, is, po;
    logic [31:0] pa;
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, gnt, pr, rv, rd, pu, is, po, pa);
  endtask

  task automatic zero_inputs();
    in_q_valid_i = 1'b0; in_q_addr_i = '0; in_q_write_i = 1'b0;
    in_q_data_i = '0; in_q_strb_i = '0; out_q_ready_i = 1'b0;
    in_p_ready_i = 1'b0; out_p_valid_i = 1'b0; out_p_data_i = '0;
  endtask

  task automatic model_clear();
    mq.delete(); mr.delete(); mcred = 0; merr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    zero_inputs();
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Random-phase TCDM responder: in order, 1..3 cycles after each read issue.
  int          cyc = 0;
  int          last_t = -1;
  int          sched_t[$];
  logic [31:0] sched_a[$];

  task automatic rand_cycle(input bit drain);
    bit rv, qv, wr, gnt, pr, pu, is, po;
    logic [31:0] rd, pa;
    int t;
    rv = 1'b0;
    rd = 32'h0;
    if (sched_t.size() > 0 && sched_t[0] == cyc) begin
      rv = 1'b1;
      rd = rdat(sched_a[0]);
      void'(sched_t.pop_front());
      void'(sched_a.pop_front());
    end
    qv  = !drain && ($urandom_range(0, 3) != 0);
    wr  = ($urandom_range(0, 2) == 0);
    gnt = drain || ($urandom_range(0, 3) != 0);
    pr  = drain || ($urandom_range(0, 2) != 0);
    step(qv, $urandom, wr, $urandom, 4'($urandom), gnt, pr, rv, rd, pu, is, po, pa);
    if (is) begin
      t = cyc + 1 + int'($urandom_range(0, 2));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      sched_t.push_back(t);
      sched_a.push_back(pa);
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pu, is, po, pend;
    logic [31:0] pa, prev_a;
    int sent, issued, ndr, w, k;
    logic [31:0] emerged[$];

    // Reset values
    do_reset();
    #1;
    chk("rst_in_q_ready", in_q_ready_o, 1);
    chk("rst_out_q_valid", out_q_valid_o, 0);
    chk("rst_in_p_valid", in_p_valid_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_out_q_addr", out_q_addr_o, 0);
    chk("rst_in_p_data", in_p_data_o, 0);

    // Single read at 0x100, response two cycles after the grant
    step(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0, pu, is, po, pa);
    chk("t1_not_yet", out_q_valid_o, 0);
    idle(1, 0, 0, 0);
    chk("t1_valid", out_q_valid_o, 1);
    chk("t1_addr", out_q_addr_o, 32'h100);
    idle(1, 0, 0, 0);
    chk("t1_credit1", credit_o, 1);
    chk("t1_valid_drop", out_q_valid_o, 0);
    idle(0, 0, 1, 32'hDEAD_BEEF);
    idle(0, 1, 0, 0);
    chk("t1_pvalid", in_p_valid_o, 1);
    chk("t1_pdata", in_p_data_o, 32'hDEAD_BEEF);
    idle(0, 0, 0, 0);
    chk("t1_credit0", credit_o, 0);
    chk("t1_pvalid0", in_p_valid_o, 0);

    // Six back-to-back reads, no upstream pop, immediate responses
    sent = 0; issued = 0; pend = 0; prev_a = 0;
    for (int c = 0; c < 12; c++) begin
      step(sent < 6, 32'h200 + 32'(4 * sent), 0, 0, 4'h0, 1, 0, pend, rdat(prev_a),
           pu, is, po, pa);
      if (pu) sent++;
      pend = is;
      if (is) begin issued++; prev_a = pa; end
    end
    chk("t2_issued4", issued, 4);
    idle(1, 0, 0, 0);
    chk("t2_credit4", credit_o, 4);
    chk("t2_blocked", out_q_valid_o, 0);
    chk("t2_pvalid", in_p_valid_o, 1);
    chk("t2_req_full", in_q_ready_o, 0);
    ndr = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0, 0, 4'h0, 1, 1, pend, rdat(prev_a), pu, is, po, pa);
      if (in_p_valid_o) begin
        chk("t2_drain_order", in_p_data_o, rdat(32'h200 + 32'(4 * ndr)));
        ndr++;
      end
      pend = is;
      if (is) begin issued++; prev_a = pa; end
    end
    chk("t2_drained6", ndr, 6);
    chk("t2_issued6", issued, 6);

    // Three writes with the grant held low for five cycles
    w = 0;
    for (int c = 0; c < 5; c++) begin
      step(w < 3, 32'h400 + 32'(4 * w), 1, 32'h1111_0000 + 32'(w), 4'hF - 4'(w), 0, 0, 0, 0,
           pu, is, po, pa);
      if (pu) w++;
      if (c >= 1) chk("t3_hold_addr", out_q_addr_o, 32'h400);
    end
    chk("t3_pushed2", w, 2);
    chk("t3_not_ready", in_q_ready_o, 0);
    emerged.delete();
    for (int c = 0; c < 10; c++) begin
      step(w < 3, 32'h400 + 32'(4 * w), 1, 32'h1111_0000 + 32'(w), 4'hF - 4'(w), 1, 0, 0, 0,
           pu, is, po, pa);
      if (pu) w++;
      if (po) emerged.push_back(pa);
    end
    chk("t3_emerged3", emerged.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < emerged.size()) chk("t3_order", emerged[i], 32'h400 + 32'(4 * i));
    end
    chk("t3_credit0", credit_o, 0);

    // Response pop and read issue in the same cycle at credit 2
    step(1, 32'h300, 0, 0, 4'h0, 0, 0, 0, 0, pu, is, po, pa);
    step(1, 32'h304, 0, 0, 4'h0, 1, 0, 0, 0, pu, is, po, pa);
    step(1, 32'h308, 0, 0, 4'h0, 1, 0, 1, rdat(32'h300), pu, is, po, pa);
    idle(1, 1, 1, rdat(32'h304));
    chk("t4_credit_before", credit_o, 2);
    chk("t4_issue", out_q_valid_o, 1);
    chk("t4_pop", in_p_valid_o, 1);
    idle(0, 0, 0, 0);
    chk("t4_credit_after", credit_o, 2);
    idle(0, 1, 1, rdat(32'h308));
    idle(0, 1, 0, 0);
    idle(0, 1, 0, 0);
    idle(0, 0, 0, 0);
    chk("t4_credit_end", credit_o, 0);

    // Stray response with no credit
    idle(0, 0, 1, 32'h1234);
    idle(0, 0, 0, 0);
    chk("t5_err", err_o, 1);
    chk("t5_no_pvalid", in_p_valid_o, 0);
    for (int c = 0; c < 3; c++) idle(0, 1, 0, 0);
    chk("t5_err_sticky", err_o, 1);

    // Asynchronous reset mid-burst with two reads in flight
    step(1, 32'h500, 0, 0, 4'h0, 0, 0, 0, 0, pu, is, po, pa);
    step(1, 32'h504, 0, 0, 4'h0, 1, 0, 0, 0, pu, is, po, pa);
    step(1, 32'h508, 0, 0, 4'h0, 1, 0, 0, 0, pu, is, po, pa);
    step(1, 32'h50C, 1, 32'hCAFE_0000, 4'h3, 0, 0, 0, 0, pu, is, po, pa);
    chk("t6_pre_valid", out_q_valid_o, 1);
    chk("t6_pre_credit", credit_o, 2);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    zero_inputs();
    #1;
    chk("t6_rst_valid", out_q_valid_o, 0);
    chk("t6_rst_ready", in_q_ready_o, 1);
    chk("t6_rst_pvalid", in_p_valid_o, 0);
    chk("t6_rst_credit", credit_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_addr", out_q_addr_o, 0);
    chk("t6_rst_data", out_q_data_o, 0);
    chk("t6_rst_pdata", in_p_data_o, 0);
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(0, 0, 1, rdat(32'h500));
    idle(0, 0, 1, rdat(32'h504));
    idle(0, 0, 0, 0);
    chk("t6_post_err", err_o, 1);
    chk("t6_post_pvalid", in_p_valid_o, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    k = 0;
    while ((mq.size() > 0 || mr.size() > 0 || sched_t.size() > 0 || mcred != 0) && k < 300) begin
      rand_cycle(1'b1);
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d cycles, required fewer than 300", k);
    end
    idle(0, 0, 0, 0);
    chk("final_credit", credit_o, 0);
    chk("final_err", err_o, 0);
    chk("final_pvalid", in_p_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snax_tcdm_credit_buffer.md
Name: snax_tcdm_credit_buffer

Overview:
- Per-port elastic stage between the SNAX HWPE-to-reqrsp translator output and the TCDM interconnect; one instance per TCDM port.
- Decouples accelerator request issue from interconnect back-pressure using a request FIFO.
- Bounds outstanding reads with a credit counter so that every TCDM read response has a guaranteed slot in a local response FIFO.
- TCDM responses carry no ready; the response FIFO absorbs them while the accelerator stalls.

Parameters:
- DataWidth, 32, TCDM data width in bits; strobe width is DataWidth/8.
- AddrWidth, 32, TCDM address width.
- ReqDepth, 2, request FIFO entries; minimum 1.
- MaxOutstanding, 4, maximum reads in flight; also the response FIFO depth; minimum 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- in_q_valid_i  in  1  upstream request valid.
- in_q_ready_o  out  1  upstream request ready.
- in_q_addr_i  in  AddrWidth  request address.
- in_q_write_i  in  1  1 = write, 0 = read.
- in_q_data_i  in  DataWidth  write data.
- in_q_strb_i  in  DataWidth/8  byte strobes.
- in_p_valid_o  out  1  read response valid to upstream.
- in_p_ready_i  in  1  upstream accepts response.
- in_p_data_o  out  DataWidth  read data to upstream.
- out_q_valid_o  out  1  request valid to TCDM.
- out_q_ready_i  in  1  TCDM grant.
- out_q_addr_o  out  AddrWidth  forwarded address.
- out_q_write_o  out  1  forwarded write flag.
- out_q_data_o  out  DataWidth  forwarded write data.
- out_q_strb_o  out  DataWidth/8  forwarded strobes.
- out_p_valid_i  in  1  TCDM read response valid; no ready.
- out_p_data_i  in  DataWidth  TCDM read data.
- credit_o  out  $clog2(MaxOutstanding+1)  reads issued but not yet popped upstream.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (async on rst_i high):
  - Both FIFOs empty; credit = 0; err_o = 0.
  - in_q_ready_o = 1; out_q_valid_o = 0; in_p_valid_o = 0.
  - All data and address outputs = 0.
- Request FIFO (registered, not fall-through):
  - Push on in_q_valid_i & in_q_ready_o.
  - in_q_ready_o = !full. A same-cycle pop does not free a slot for a push when full.
  - Minimum latency: 1 cycle from input handshake to out_q_valid_o.
  - out_q_valid_o = !empty & issue_ok, where issue_ok = head is a write OR credit < MaxOutstanding.
  - Head payload is held stable while out_q_valid_o = 1 and out_q_ready_i = 0.
  - Once asserted, out_q_valid_o does not drop until the handshake completes. Credit only rises on a read issue, so issue_ok cannot fall while a head is waiting.
  - Order is preserved: a read head blocked on credit also blocks any writes behind it.
- Credit counter:
  - +1 on a read handshake out_q_valid_o & out_q_ready_i & !out_q_write_o.
  - -1 on a response pop in_p_valid_o & in_p_ready_i.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding.
- Response FIFO (depth MaxOutstanding):
  - Push on out_p_valid_i; pop on in_p_valid_o & in_p_ready_i.
  - in_p_valid_o = !empty. Data is registered, so minimum latency is 1 cycle from out_p_valid_i to in_p_valid_o.
  - Push and pop allowed in the same cycle, including when full.
- Error conditions:
  - out_p_valid_i while (credit - response FIFO occupancy) == 0 is a stray response: it is dropped and err_o is set.
  - err_o clears only on reset.
  - Overflow is impossible by construction; if it occurs anyway, the response is dropped and err_o is set.
- Writes generate no response and consume no credit.

Optional Feature:
- Macro: SNAX_TCDM_BUF_PERF_EN.
- When defined, adds two 32-bit saturating counters:
  - perf_stall_credit_o: cycles with a read head blocked by credit.
  - perf_stall_gnt_o: cycles with out_q_valid_o=1 and out_q_ready_i=0.
  - Both reset to 0, and both clear synchronously on input perf_clr_i.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Single read, addr 0x100, grant held 1, TCDM responds 0xDEADBEEF 2 cycles later:
  - out_q_valid_o 1 cycle after input.
  - credit_o goes 1 then 0 after the pop.
  - in_p_data_o = 0xDEADBEEF.
- 6 back-to-back reads, MaxOutstanding=4, in_p_ready_i=0, immediate responses: exactly 4 issued; credit_o=4; out_q_valid_o=0; releasing in_p_ready_i drains the 4 responses in order and then issues the remaining 2.
- Grant held 0 for 5 cycles with ReqDepth=2 and 3 writes offered: in_q_ready_o=0 after 2 pushes; payload stable; all 3 writes emerge in order once granted; credit stays 0.
- Response pop and read issue in the same cycle at credit=2: credit_o stays 2.
- out_p_valid_i with credit 0: err_o=1 and stays 1; no in_p_valid_o.
- rst_i asserted mid-burst with 2 reads in flight: outputs go to reset values asynchronously; post-reset responses set err_o.
